data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised data memory that services the load/store accesses the control unit decodes: the responder side of the mem_write and LW/SW path.
- Address, store data and write enable come from the datapath. The block returns sized, sign- or zero-extended load data to the result mux.
- After reset it runs a sequential zero-fill sweep. Stores are blocked until the sweep completes and ready is asserted.

Parameters:
- WORDS, 64, number of 32-bit words; must be a power of two and at least 4.
- WIDTH, 32, data width; fixed at 32, listed for package consistency.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  32  byte address from the ALU result.
- write_data  input  32  store data (rs2).
- mem_write  input  1  store request from the control unit.
- func3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- read_data  output  32  extended load data.
- ready  output  1  high once the zero-fill sweep is complete.
- misaligned  output  1  high when the current access violates natural alignment.

Behaviour:
- One clock (clk); reset is synchronous and active-high. In a cycle where reset is high at the edge: state <= CLEAR, clear counter <= 0, ready = 0.
- States:
  - CLEAR: each cycle, write 0 to word[counter], then counter += 1. When counter == WORDS-1, write that word and go to READY at the next edge. The sweep takes exactly WORDS cycles after reset deasserts.
  - READY: normal operation; ready = 1. No exit except reset.
- Reset asserted mid-sweep or in READY: return to CLEAR with counter 0. Memory contents are not otherwise touched by reset.
- Word index = address[log2(WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo WORDS*4.
- Byte lane = address[1:0].
- misaligned is combinational:
  - high when func3 is H/HU and address[0] == 1, or func3 is W and address[1:0] != 0;
  - also high for reserved func3 values (011, 110, 111);
  - otherwise low.
- Store, written at the edge, only when state == READY, mem_write == 1 and misaligned == 0:
  - B: byte lane <= write_data[7:0].
  - H: halfword at lane 0 or 2 <= write_data[15:0].
  - W: full word.
  - Unselected bytes are preserved.
- Stores during CLEAR or when misaligned are dropped silently.
- Load data is an asynchronous (combinational) read:
  - B sign-extends the selected byte; BU zero-extends it.
  - H sign-extends the selected halfword; HU zero-extends it.
  - W returns the full word.
- read_data = 0 when state == CLEAR or misaligned == 1.
- Same-cycle store and load to the same word: read_data shows the pre-edge value. The new value is visible after the edge.
- During reset: ready = 0 and read_data = 0. misaligned still reflects its inputs.

Decomposition:
- Shared package core_pkg holds:
  - func3 encodings as constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - a typedef for the memory state enum {CLEAR, READY}.
- One natural sub-module, load_extend: purely combinational word + lane + func3 -> extended 32-bit result.
- Store byte-merge logic stays inline.

Test Plan:
- Sweep: pre-load word 5 = 32'hDEADBEEF through a backdoor, pulse reset one cycle. Required: ready low for exactly 64 cycles, then high; LW @0x14 -> 32'h00000000.
- Word access: SW 32'h12345678 @0x20, then LW @0x20 -> 32'h12345678. LB @0x21 -> 32'h00000056. LH @0x22 -> 32'h00001234.
- Sign extension: SW 32'h80FF7F80 @0x08. Required:
  - LB @0x08 -> 32'hFFFFFF80; LBU @0x08 -> 32'h00000080.
  - LH @0x0A -> 32'hFFFF80FF; LHU @0x0A -> 32'h000080FF.
- Partial store: word @0x10 = 32'hAABBCCDD; SB 32'h00000011 @0x13 -> LW @0x10 = 32'h11BBCCDD. SH 32'h00002233 @0x10 -> 32'h11BB2233.
- Misalignment: SW @0x06 with mem_write high. Required: misaligned = 1, word @0x04 unchanged, read_data = 0. LH @0x05 also gives misaligned = 1.
- Reset mid-sweep: assert reset at sweep cycle 30. Required: ready stays low for a full 64 cycles after deassert. A store attempted during the sweep is dropped, so a later LW at that address -> 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared load/store encodings and memory sequencing state for the data memory.
package core_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } mem_state_e;

   // Reserved size encodings are reported as misaligned so they never touch memory.
   function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] lane);
      logic bad;
      case (f3)
         F3_B, F3_BU: bad = 1'b0;
         F3_H, F3_HU: bad = lane[0];
         F3_W:        bad = (lane != 2'b00);
         default:     bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// Selects the addressed byte/halfword of a memory word and sign- or zero-extends it.
module load_extend
   import core_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  func3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{lane_i, 3'b000} +: 8];
      half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
      result_o = '0;
      case (func3_i)
         F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result_o = {24'h000000, byte_sel};
         F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result_o = {16'h0000, half_sel};
         F3_W:    result_o = word_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with a post-reset zero-fill sweep, byte/half/word
// stores and combinational extended loads.
module data_memory
   import core_pkg::*;
#(
   parameter int unsigned WORDS = 64,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      address,
   input  logic [WIDTH-1:0] write_data,
   input  logic             mem_write,
   input  logic [2:0]       func3,
   output logic [WIDTH-1:0] read_data,
   output logic             ready,
   output logic             misaligned
);

   localparam int unsigned IDX_W = $clog2(WORDS);

   mem_state_e       state_q, state_d;
   logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
   logic             clr_we;
   logic             store_we;
   logic [WIDTH-1:0] mem_q [WORDS];

   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic [WIDTH-1:0] word_rd;
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] load_ext;
   logic             unused_addr;

   assign idx         = address[IDX_W+1:2];
   assign lane        = address[1:0];
   assign unused_addr = ^address[31:IDX_W+2];
   assign word_rd     = mem_q[idx];

   assign misaligned = access_misaligned(func3, lane);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we    = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) state_d = READY;
         end
         READY:   state_d = READY;
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   assign store_we = (state_q == READY) && mem_write && !misaligned && !reset;

   // Size comes from func3[1:0]; unselected bytes keep the pre-edge word.
   always_comb begin
      merged = word_rd;
      case (func3[1:0])
         2'b00:   merged[{lane, 3'b000} +: 8]     = write_data[7:0];
         2'b01:   merged[{lane[1], 4'b0000} +: 16] = write_data[15:0];
         default: merged = write_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
         end else if (store_we) begin
            mem_q[idx] <= merged;
         end
      end
   end

   load_extend u_load_extend (
      .word_i   (word_rd),
      .lane_i   (lane),
      .func3_i  (func3),
      .result_o (load_ext)
   );

   assign ready     = (state_q == READY) && !reset;
   assign read_data = (ready && !misaligned) ? load_ext : '0;

endmodule

// File: tb/tb_data_memory.sv
// Randomized and directed checks of data_memory against a byte-array reference model.
module tb_data_memory;

   localparam int WORDS = 64;
   localparam int BYTES = WORDS * 4;

   logic        clk;
   logic        reset;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        mem_write;
   logic [2:0]  func3;
   logic [31:0] read_data;
   logic        ready;
   logic        misaligned;

   int total = 0;
   int bad   = 0;

   data_memory #(.WORDS(WORDS), .WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .write_data (write_data),
      .mem_write  (mem_write),
      .func3      (func3),
      .read_data  (read_data),
      .ready      (ready),
      .misaligned (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model: flat byte array, little-endian ----------------
   logic [7:0] mb [BYTES];
   int         sweep_left = 0;
   bit         model_valid = 1'b0;

   function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'b000, 3'b100: return 1'b0;
         3'b001, 3'b101: return a[0];
         3'b010:         return a[1:0] != 2'b00;
         default:        return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a32);
      int unsigned a;
      logic [31:0] r;
      a = a32 & (BYTES - 1);
      case (f3)
         3'b000: r = {{24{mb[a][7]}}, mb[a]};
         3'b100: r = {24'h0, mb[a]};
         3'b001: r = {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
         3'b101: r = {16'h0, mb[a+1], mb[a]};
         3'b010: r = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // Checks outputs on each falling edge, then applies the upcoming rising edge to the model.
   initial begin
      bit          e_rdy, e_mis;
      logic [31:0] e_rd;
      int unsigned a;
      forever begin
         @(negedge clk);
         e_mis = ref_mis(func3, address);
         e_rdy = !reset && (sweep_left == 0);
         if (model_valid) begin
            e_rd = (!e_rdy || e_mis) ? 32'h0 : ref_load(func3, address);
            chk("rd",  read_data, e_rd);
            chk("rdy", {31'h0, ready}, {31'h0, e_rdy});
            chk("mis", {31'h0, misaligned}, {31'h0, e_mis});
         end
         if (reset) begin
            sweep_left  = WORDS;
            model_valid = 1'b1;
         end else if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0)
               for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
         end else if (model_valid && mem_write && !e_mis) begin
            a = address & (BYTES - 1);
            mb[a] = write_data[7:0];
            if (func3 == 3'b001 || func3 == 3'b010) mb[a+1] = write_data[15:8];
            if (func3 == 3'b010) begin
               mb[a+2] = write_data[23:16];
               mb[a+3] = write_data[31:24];
            end
         end
      end
   end

   // ---------------- stimulus helpers (inputs change 1 time unit after rising edges) ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      address = a; write_data = d; func3 = f3; mem_write = 1'b1;
      step();
      mem_write = 1'b0;
   endtask

   task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp, input string name);
      address = a; func3 = f3; mem_write = 1'b0;
      @(negedge clk);
      chk(name, read_data, exp);
      step();
   endtask

   task automatic count_sweep(output int n);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (ready) break;
         n++;
      end
      step();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1; address = '0; write_data = '0; mem_write = 1'b0; func3 = 3'b010;
      step();
      step();
      reset = 1'b0;
      count_sweep(n);
      chk("sweep_len0", n, 64);

      // Sweep clears a previously written word
      st(32'h14, 32'hDEADBEEF, 3'b010);
      ld(32'h14, 3'b010, 32'hDEADBEEF, "preload");
      st(32'h40, 32'h55AA55AA, 3'b010);
      pulse_reset();
      count_sweep(n);
      chk("sweep_len1", n, 64);
      ld(32'h14, 3'b010, 32'h00000000, "sweep_clr");

      // Word access
      st(32'h20, 32'h12345678, 3'b010);
      ld(32'h20, 3'b010, 32'h12345678, "lw20");
      ld(32'h21, 3'b000, 32'h00000056, "lb21");
      ld(32'h22, 3'b001, 32'h00001234, "lh22");

      // Sign extension
      st(32'h08, 32'h80FF7F80, 3'b010);
      ld(32'h08, 3'b000, 32'hFFFFFF80, "lb08");
      ld(32'h08, 3'b100, 32'h00000080, "lbu08");
      ld(32'h0A, 3'b001, 32'hFFFF80FF, "lh0a");
      ld(32'h0A, 3'b101, 32'h000080FF, "lhu0a");

      // Partial stores
      st(32'h10, 32'hAABBCCDD, 3'b010);
      st(32'h13, 32'h00000011, 3'b000);
      ld(32'h10, 3'b010, 32'h11BBCCDD, "sb13");
      st(32'h10, 32'h00002233, 3'b001);
      ld(32'h10, 3'b010, 32'h11BB2233, "sh10");

      // Misaligned store is dropped
      st(32'h04, 32'h01020304, 3'b010);
      address = 32'h06; write_data = 32'hFFFFFFFF; func3 = 3'b010; mem_write = 1'b1;
      @(negedge clk);
      chk("mis_sw", {31'h0, misaligned}, 32'h1);
      chk("mis_rd", read_data, 32'h0);
      step();
      mem_write = 1'b0;
      ld(32'h04, 3'b010, 32'h01020304, "mis_keep");
      address = 32'h05; func3 = 3'b001;
      @(negedge clk);
      chk("mis_lh", {31'h0, misaligned}, 32'h1);
      step();

      // Upper address bits alias
      st(32'h10000030, 32'h0BADF00D, 3'b010);
      ld(32'h00000030, 3'b010, 32'h0BADF00D, "alias");

      // Reset mid-sweep, with a store attempted during the sweep
      pulse_reset();
      for (int i = 0; i < 30; i++) begin
         address = 32'h40; write_data = 32'hCAFEF00D; func3 = 3'b010;
         mem_write = (i == 10);
         step();
      end
      mem_write = 1'b0;
      pulse_reset();
      count_sweep(n);
      chk("sweep_mid", n, 64);
      ld(32'h40, 3'b010, 32'h00000000, "drop_clr");

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         address    = a;
         func3      = f3;
         write_data = $urandom;
         mem_write  = ($urandom_range(0, 1) == 1) && (f3 != 3'b100) && (f3 != 3'b101);
         reset      = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0;
      mem_write = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
